// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle for mux4_rr_arbiter: four producer channels in, one consumer channel out.
// slave is the arbiter's view; master is the producer/consumer side.
interface mux4_rr_arbiter_if #(
    parameter int DATA_SIZE = 8
);
    logic [4*DATA_SIZE-1:0] in_data;
    logic [3:0]             in_valid;
    logic [3:0]             in_last;
    logic [3:0]             in_ready;
    logic [DATA_SIZE-1:0]   out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             sel;
    logic                   grant_valid;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, sel, grant_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, sel, grant_valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over a shared 4:1 datapath mux with a one-entry registered output stage.
// Define MUX4_RR_ARBITER_BURST_LOCK_EN to hold the grant on one channel until its in_last transfer.
module mux4 #(
    parameter int DATA_SIZE = 8
) (
    input  logic [4*DATA_SIZE-1:0] data_i,
    input  logic [1:0]             sel_i,
    output logic [DATA_SIZE-1:0]   data_o
);
    always_comb begin
        case (sel_i)
            2'd0:    data_o = data_i[0*DATA_SIZE +: DATA_SIZE];
            2'd1:    data_o = data_i[1*DATA_SIZE +: DATA_SIZE];
            2'd2:    data_o = data_i[2*DATA_SIZE +: DATA_SIZE];
            default: data_o = data_i[3*DATA_SIZE +: DATA_SIZE];
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int DATA_SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    mux4_rr_arbiter_if.slave    bus
);
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic [DATA_SIZE-1:0] mux_data;
    logic [1:0]           scan_idx, cand;
    logic                 scan_found;
    logic [1:0]           sel_w;
    logic                 req_w;
    logic                 grant_valid_w;
    logic                 load;

`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
    logic                 lock_q, lock_d;
    logic [1:0]           lock_idx_q, lock_idx_d;
`else
    logic                 unused_in_last;
    assign unused_in_last = ^bus.in_last;
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        scan_idx   = rr_ptr_q;
        scan_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!scan_found && bus.in_valid[cand]) begin
                scan_idx   = cand;
                scan_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_w = scan_idx;
        req_w = scan_found;
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
        if (lock_q) begin
            sel_w = lock_idx_q;
            req_w = bus.in_valid[lock_idx_q];
        end
`endif
    end

    // A draining full stage may reload in the same cycle, hence the out_ready -> in_ready path.
    assign grant_valid_w = req_w && !reset;
    assign load          = grant_valid_w && (!out_valid_q || bus.out_ready);

    mux4 #(.DATA_SIZE(DATA_SIZE)) u_mux4 (
        .data_i (bus.in_data),
        .sel_i  (sel_w),
        .data_o (mux_data)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
`endif
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
            if (lock_q) begin
                if (bus.in_last[sel_w]) begin
                    lock_d   = 1'b0;
                    rr_ptr_d = lock_idx_q + 2'd1;
                end
            end else begin
                rr_ptr_d = sel_w + 2'd1;
                if (!bus.in_last[sel_w]) begin
                    lock_d     = 1'b1;
                    lock_idx_d = sel_w;
                end
            end
`else
            rr_ptr_d = sel_w + 2'd1;
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    assign bus.in_ready    = load ? (4'b0001 << sel_w) : 4'b0000;
    assign bus.sel         = sel_w;
    assign bus.grant_valid = grant_valid_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed table-driven bench for mux4_rr_arbiter; each row is one clock of stimulus with
// the expected combinational grant in that cycle and the expected output stage after the edge.
module tb_mux4_rr_arbiter;
    localparam int DW = 8;

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [3:0]  il;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic [1:0]  exp_sel;
        logic        exp_gv;
        logic        exp_ov;
        logic [7:0]  exp_od;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux4_rr_arbiter_if #(.DATA_SIZE(DW)) bus ();

    mux4_rr_arbiter #(.DATA_SIZE(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] iv, input logic [3:0] il,
                                input logic [31:0] dat, input logic ordy, input logic [3:0] ir,
                                input logic [1:0] sl, input logic gv, input logic ov,
                                input logic [7:0] od);
        vec_t v;
        v.rst = rst; v.iv = iv; v.il = il; v.dat = dat; v.ordy = ordy;
        v.exp_ir = ir; v.exp_sel = sl; v.exp_gv = gv; v.exp_ov = ov; v.exp_od = od;
        return v;
    endfunction

    task automatic apply(input string tag, input int idx, input vec_t v);
        reset         = v.rst;
        bus.in_valid  = v.iv;
        bus.in_last   = v.il;
        bus.in_data   = v.dat;
        bus.out_ready = v.ordy;
        #2;
        check($sformatf("%s%0d in_ready", tag, idx), 32'(bus.in_ready), 32'(v.exp_ir));
        check($sformatf("%s%0d sel", tag, idx), 32'(bus.sel), 32'(v.exp_sel));
        check($sformatf("%s%0d grant_valid", tag, idx), 32'(bus.grant_valid), 32'(v.exp_gv));
        @(posedge clk);
        #1;
        check($sformatf("%s%0d out_valid", tag, idx), 32'(bus.out_valid), 32'(v.exp_ov));
        check($sformatf("%s%0d out_data", tag, idx), 32'(bus.out_data), 32'(v.exp_od));
    endtask

    initial begin
        vec_t vecs[$];
        vec_t lvecs[$];
        logic [31:0] d;
        logic [31:0] d5a;
        int          lat;

        d   = 32'h1312_1110;
        d5a = 32'h135A_1110;

        // Single request, wrap check via rr_ptr=3, rotation, stall, drain, reset-on-load.
        vecs.push_back(mk(1, 4'b0000, 4'hF, d,   1, 4'b0000, 2'd0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0100, 4'hF, d5a, 1, 4'b0100, 2'd2, 1, 1, 8'h5A));
        vecs.push_back(mk(0, 4'b1111, 4'hF, d,   1, 4'b1000, 2'd3, 1, 1, 8'h13));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 4'b1111, 4'hF, d, 1, 4'(1 << (i % 4)), 2'(i % 4), 1, 1,
                              8'(8'h10 + (i % 4))));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 4'b0011, 4'hF, d, 0, 4'b0000, 2'd0, 1, 1, 8'h13));
        vecs.push_back(mk(0, 4'b0011, 4'hF, d, 1, 4'b0001, 2'd0, 1, 1, 8'h10));
        vecs.push_back(mk(0, 4'b0100, 4'hF, d, 1, 4'b0100, 2'd2, 1, 1, 8'h12));
        vecs.push_back(mk(0, 4'b0001, 4'hF, d, 1, 4'b0001, 2'd0, 1, 1, 8'h10));
        vecs.push_back(mk(0, 4'b1111, 4'hF, d, 1, 4'b0010, 2'd1, 1, 1, 8'h11));
        vecs.push_back(mk(0, 4'b0000, 4'hF, d, 1, 4'b0000, 2'd2, 0, 0, 8'h11));
        vecs.push_back(mk(0, 4'b0000, 4'hF, d, 0, 4'b0000, 2'd2, 0, 0, 8'h11));
        vecs.push_back(mk(0, 4'b0010, 4'hF, d, 1, 4'b0010, 2'd1, 1, 1, 8'h11));
        vecs.push_back(mk(1, 4'b1111, 4'hF, d, 1, 4'b0000, 2'd2, 0, 0, 8'h00));
        vecs.push_back(mk(0, 4'b1111, 4'hF, d, 1, 4'b0001, 2'd0, 1, 1, 8'h10));
        vecs.push_back(mk(0, 4'b0000, 4'hF, d, 1, 4'b0000, 2'd1, 0, 0, 8'h10));
        vecs.push_back(mk(0, 4'b1000, 4'hF, d, 0, 4'b1000, 2'd3, 1, 1, 8'h13));
        vecs.push_back(mk(0, 4'b0001, 4'hF, d, 0, 4'b0000, 2'd0, 1, 1, 8'h13));

        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_last   = '1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply("row", i, vecs[i]);

        // Stage is full and stalled: raising out_ready alone must not move out_data before the edge.
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        #1;
        check("comb out_data", 32'(bus.out_data), 32'h13);
        check("comb out_valid", 32'(bus.out_valid), 32'h1);
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(bus.out_valid), 32'h0);

        // Bounded wait for a single request to appear at the output; rr_ptr=0 here.
        bus.in_valid = 4'b0010;
        bus.in_data  = d;
        lat = 0;
        while (!bus.out_valid && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd1);
        check("latency out_data", 32'(bus.out_data), 32'h11);

`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
        // Channel 1 burst A1,A2,A3 with ch0 always requesting; ch1 drops mid-burst once.
        lvecs.push_back(mk(1, 4'b0000, 4'hF, 32'h0000_A150, 1, 4'b0000, 2'd0, 0, 0, 8'h00));
        lvecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_A150, 1, 4'b0001, 2'd0, 1, 1, 8'h50));
        lvecs.push_back(mk(0, 4'b0011, 4'b0000, 32'h0000_A150, 1, 4'b0010, 2'd1, 1, 1, 8'hA1));
        lvecs.push_back(mk(0, 4'b0011, 4'b0000, 32'h0000_A250, 1, 4'b0010, 2'd1, 1, 1, 8'hA2));
        lvecs.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_A250, 1, 4'b0000, 2'd1, 0, 0, 8'hA2));
        lvecs.push_back(mk(0, 4'b0011, 4'b0010, 32'h0000_A350, 1, 4'b0010, 2'd1, 1, 1, 8'hA3));
        lvecs.push_back(mk(0, 4'b0011, 4'b0011, 32'h0000_A350, 1, 4'b0001, 2'd0, 1, 1, 8'h50));
        for (int i = 0; i < lvecs.size(); i++) apply("lock", i, lvecs[i]);
`else
        lvecs.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
